// File: rtl/hazard_unit_id_pkg.sv
// Shared definitions for the ID-stage hazard unit: register-address width,
// the shadow pipeline-stage record and the source-operand match helper.
package hazard_unit_id_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Destination-register state of one in-flight instruction (EX or MEM)
  typedef struct packed {
    logic                  v;   // slot holds a real instruction
    logic                  rw;  // instruction writes a non-zero register
    logic                  mr;  // instruction is a load
    logic [REG_ADDR_W-1:0] wa;  // destination register
  } shadow_t;

  // True when the ID instruction reads register x; $0 never matches
  function automatic logic reg_match(
    input logic [REG_ADDR_W-1:0] x,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  use_rs,
    input logic                  use_rt
  );
    return (x != REG_ZERO) && ((use_rs && (rs == x)) || (use_rt && (rt == x)));
  endfunction

endpackage

// File: rtl/hazard_unit_id_muldiv_busy_ctr.sv
// Mult/div busy down-counter. Loading sets it to LAT; it then counts down to
// zero one step per clock. o_busy is high while the count is non-zero.
// Ports: clk, rst (sync, active-high), i_load, o_busy.
module muldiv_busy_ctr #(
  parameter int unsigned LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy
);

  // LAT = 0 still needs a 1-bit counter; it simply never leaves zero
  localparam int unsigned CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_unit_id.sv
// ID-stage hazard unit. Shadows the destination-register state of the EX and
// MEM instructions, raises a combinational stall when ID forwarding cannot
// resolve a dependency (load-use, branch on EX result, branch on MEM load,
// busy mult/div), publishes the MEM-stage write pair for the forwarding unit
// and counts stalled cycles with a saturating counter.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_*                decoded fields of the instruction in ID
//   flush               squash the ID instruction
//   stall               hold PC/IF-ID, bubble into ID/EX (combinational)
//   reg_write_mem       MEM-stage register-write enable (registered)
//   reg_w_addr_mem      MEM-stage destination register (registered)
//   stall_count         saturating stalled-cycle count (registered)
module hazard_unit_id
  import hazard_unit_id_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_is_branch,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_w_addr,
  input  logic                  id_is_muldiv,
  input  logic                  id_reads_hilo,
  input  logic                  flush,
  output logic                  stall,
  output logic                  reg_write_mem,
  output logic [REG_ADDR_W-1:0] reg_w_addr_mem,
  output logic [CNT_W-1:0]      stall_count
);

  shadow_t          r_ex;
  shadow_t          r_mem;
  shadow_t          w_ex_next;
  logic [CNT_W-1:0] r_stall_count;

  logic w_match_ex;
  logic w_match_mem;
  logic w_load_use;
  logic w_br_ex;
  logic w_br_mem_ld;
  logic w_md_busy;
  logic w_muldiv_busy;
  logic w_stall;
  logic w_accept;

  assign w_match_ex  = reg_match(r_ex.wa,  id_rs, id_rt, id_use_rs, id_use_rt);
  assign w_match_mem = reg_match(r_mem.wa, id_rs, id_rt, id_use_rs, id_use_rt);

  // Dependencies that ID-stage forwarding cannot cover
  assign w_load_use  = r_ex.v && r_ex.rw && r_ex.mr && w_match_ex;
  assign w_br_ex     = id_is_branch && r_ex.v && r_ex.rw && w_match_ex;
  assign w_br_mem_ld = id_is_branch && r_mem.v && r_mem.rw && r_mem.mr && w_match_mem;
  assign w_md_busy   = w_muldiv_busy && (id_is_muldiv || id_reads_hilo);

  // Flush wins over every hazard; reset also masks the stall immediately
  assign w_stall  = id_valid && !flush && !rst &&
                    (w_load_use || w_br_ex || w_br_mem_ld || w_md_busy);
  assign w_accept = id_valid && !flush && !w_stall;

  // Next EX shadow: the accepted instruction, otherwise a bubble.
  // Writes to $0 are recorded as no-write so they never reach the MEM pair.
  always_comb begin
    w_ex_next = '0;
    if (w_accept) begin
      w_ex_next.v  = 1'b1;
      w_ex_next.rw = id_reg_write && (id_w_addr != REG_ZERO);
      w_ex_next.mr = id_mem_read;
      w_ex_next.wa = id_w_addr;
    end
  end

  // Shadow EX/MEM pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
    end
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  muldiv_busy_ctr #(
    .LAT (MULDIV_LAT)
  ) u_muldiv_busy_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept && id_is_muldiv),
    .o_busy (w_muldiv_busy)
  );

  assign stall          = w_stall;
  assign reg_write_mem  = r_mem.v && r_mem.rw;
  assign reg_w_addr_mem = r_mem.wa;
  assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_hazard_unit_id.sv
// Scoreboard bench for hazard_unit_id: a driver issues one ID instruction per
// cycle and pushes the reference model's expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_hazard_unit_id;

  localparam int unsigned LAT     = 4;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit       br;
    bit       wr;
    bit       ld;
    bit [4:0] wa;
    bit       md;
    bit       hilo;
  } id_t;

  // One instruction in flight behind ID
  typedef struct packed {
    bit       v;
    bit       wr;
    bit       ld;
    bit [4:0] dst;
  } slot_t;

  typedef struct packed {
    bit       stall;
    bit       rwm;
    bit [4:0] wam;
    int       cnt;
    bit       has_dir;
    int       dir_cnt;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           id_valid;
  logic [4:0]     id_rs;
  logic [4:0]     id_rt;
  logic           id_use_rs;
  logic           id_use_rt;
  logic           id_is_branch;
  logic           id_reg_write;
  logic           id_mem_read;
  logic [4:0]     id_w_addr;
  logic           id_is_muldiv;
  logic           id_reads_hilo;
  logic           flush;
  logic           stall;
  logic           reg_write_mem;
  logic [4:0]     reg_w_addr_mem;
  logic [CW-1:0]  stall_count;

  hazard_unit_id #(
    .MULDIV_LAT (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_is_branch   (id_is_branch),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_w_addr      (id_w_addr),
    .id_is_muldiv   (id_is_muldiv),
    .id_reads_hilo  (id_reads_hilo),
    .flush          (flush),
    .stall          (stall),
    .reg_write_mem  (reg_write_mem),
    .reg_w_addr_mem (reg_w_addr_mem),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  expq[$];
  slot_t pipe[$];    // pipe[0] = instruction in EX, pipe[1] = in MEM
  int    m_cnt;
  bit    md_active;
  int    md_cyc;
  int    cyc;
  bit    pend_v;
  int    pend_c;
  bit    done;
  int    n_checks;
  int    n_fail;

  // ---------------- instruction builders ----------------
  function automatic id_t i_nop();
    id_t d;
    d = '0;
    return d;
  endfunction

  function automatic id_t i_alu(input bit [4:0] wa, input bit [4:0] rs, input bit [4:0] rt);
    id_t d;
    d = '0; d.v = 1; d.wr = 1; d.wa = wa; d.rs = rs; d.rt = rt; d.urs = 1; d.urt = 1;
    return d;
  endfunction

  function automatic id_t i_lw(input bit [4:0] wa, input bit [4:0] base);
    id_t d;
    d = '0; d.v = 1; d.wr = 1; d.ld = 1; d.wa = wa; d.rs = base; d.urs = 1;
    return d;
  endfunction

  function automatic id_t i_beq(input bit [4:0] rs, input bit [4:0] rt);
    id_t d;
    d = '0; d.v = 1; d.br = 1; d.rs = rs; d.rt = rt; d.urs = 1; d.urt = 1;
    return d;
  endfunction

  function automatic id_t i_mult(input bit [4:0] rs, input bit [4:0] rt);
    id_t d;
    d = '0; d.v = 1; d.md = 1; d.rs = rs; d.rt = rt; d.urs = 1; d.urt = 1;
    return d;
  endfunction

  function automatic id_t i_mflo(input bit [4:0] wa);
    id_t d;
    d = '0; d.v = 1; d.hilo = 1; d.wr = 1; d.wa = wa;
    return d;
  endfunction

  function automatic id_t i_rand();
    id_t d;
    d.v    = ($urandom_range(0, 9) != 0);
    d.rs   = 5'($urandom_range(0, 3));
    d.rt   = 5'($urandom_range(0, 3));
    d.urs  = 1'($urandom_range(0, 1));
    d.urt  = 1'($urandom_range(0, 1));
    d.br   = ($urandom_range(0, 4) == 0);
    d.wr   = 1'($urandom_range(0, 1));
    d.ld   = ($urandom_range(0, 2) == 0);
    d.wa   = 5'($urandom_range(0, 3));
    d.md   = ($urandom_range(0, 9) == 0);
    d.hilo = ($urandom_range(0, 5) == 0);
    return d;
  endfunction

  // Does the ID instruction read register r? Register 0 is a constant.
  function automatic bit reads(input id_t d, input bit [4:0] r);
    return (r != 0) && ((d.urs && d.rs == r) || (d.urt && d.rt == r));
  endfunction

  // Attach a fixed stall_count expectation to the next issued cycle
  task automatic expect_cnt(input int c);
    pend_v = 1'b1;
    pend_c = c;
  endtask

  // Present one ID cycle, record what the DUT must show, advance the model
  task automatic drive(input bit r, input bit fl, input id_t d);
    exp_t  e;
    slot_t ex_s;
    slot_t mem_s;
    slot_t ns;
    bit    lu, bx, bm, mb, st, acc;

    rst           = r;
    flush         = fl;
    id_valid      = d.v;
    id_rs         = d.rs;
    id_rt         = d.rt;
    id_use_rs     = d.urs;
    id_use_rt     = d.urt;
    id_is_branch  = d.br;
    id_reg_write  = d.wr;
    id_mem_read   = d.ld;
    id_w_addr     = d.wa;
    id_is_muldiv  = d.md;
    id_reads_hilo = d.hilo;

    ex_s  = pipe[0];
    mem_s = pipe[1];
    lu = ex_s.v && ex_s.wr && ex_s.ld && reads(d, ex_s.dst);
    bx = d.br && ex_s.v && ex_s.wr && reads(d, ex_s.dst);
    bm = d.br && mem_s.v && mem_s.wr && mem_s.ld && reads(d, mem_s.dst);
    mb = md_active && ((cyc - md_cyc) <= int'(LAT)) && (d.md || d.hilo);
    st = !r && d.v && !fl && (lu || bx || bm || mb);

    e.stall   = st;
    e.rwm     = mem_s.v && mem_s.wr;
    e.wam     = mem_s.v ? mem_s.dst : 5'd0;
    e.cnt     = m_cnt;
    e.has_dir = pend_v;
    e.dir_cnt = pend_c;
    pend_v    = 1'b0;
    expq.push_back(e);

    if (r) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_cnt     = 0;
      md_active = 1'b0;
    end else begin
      acc    = d.v && !fl && !st;
      ns     = '0;
      if (acc) begin
        ns.v   = 1'b1;
        ns.wr  = d.wr && (d.wa != 0);
        ns.ld  = d.ld;
        ns.dst = d.wa;
      end
      pipe.push_front(ns);
      void'(pipe.pop_back());
      if (st && m_cnt < CNT_MAX) m_cnt++;
      if (acc && d.md) begin
        md_active = 1'b1;
        md_cyc    = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall",          32'(stall),          32'(e.stall));
      chk("reg_write_mem",  32'(reg_write_mem),  32'(e.rwm));
      chk("reg_w_addr_mem", 32'(reg_w_addr_mem), 32'(e.wam));
      chk("stall_count",    32'(stall_count),    32'(e.cnt));
      if (e.has_dir) chk("stall_count_directed", 32'(stall_count), 32'(e.dir_cnt));
    end else if (done) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; done = 1'b0;
    pend_v = 1'b0; pend_c = 0;
    m_cnt = 0; md_active = 1'b0; md_cyc = 0; cyc = 0;
    pipe.push_back('0);
    pipe.push_back('0);

    rst = 1'b1; flush = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_is_branch = 0; id_reg_write = 0; id_mem_read = 0; id_w_addr = 0;
    id_is_muldiv = 0; id_reads_hilo = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then load-use: one stall, add accepted afterwards
    drive(1, 0, i_nop());
    expect_cnt(0);
    drive(0, 0, i_lw(5'd2, 5'd1));
    drive(0, 0, i_alu(5'd3, 5'd2, 5'd4));
    expect_cnt(1);
    drive(0, 0, i_alu(5'd3, 5'd2, 5'd4));
    drive(0, 0, i_nop());
    drive(0, 0, i_nop());

    // branch on a load result: two stalls
    drive(1, 0, i_nop());
    drive(0, 0, i_lw(5'd5, 5'd1));
    drive(0, 0, i_beq(5'd5, 5'd0));
    drive(0, 0, i_beq(5'd5, 5'd0));
    expect_cnt(2);
    drive(0, 0, i_beq(5'd5, 5'd0));

    // writes to $0 never stall and never reach the MEM write pair
    drive(1, 0, i_nop());
    drive(0, 0, i_alu(5'd0, 5'd1, 5'd0));
    drive(0, 0, i_beq(5'd0, 5'd0));
    expect_cnt(0);
    drive(0, 0, i_nop());
    drive(0, 0, i_nop());

    // MEM write pair, and a flushed slot behind it
    drive(0, 0, i_alu(5'd7, 5'd1, 5'd2));
    drive(0, 1, i_alu(5'd8, 5'd1, 5'd2));
    drive(0, 0, i_nop());
    drive(0, 0, i_nop());
    drive(0, 0, i_nop());

    // mult then mflo: four busy stalls, then flush masks a load-use
    drive(1, 0, i_nop());
    drive(0, 0, i_mult(5'd1, 5'd2));
    repeat (4) drive(0, 0, i_mflo(5'd3));
    expect_cnt(4);
    drive(0, 0, i_mflo(5'd3));
    drive(0, 0, i_lw(5'd2, 5'd1));
    drive(0, 1, i_alu(5'd3, 5'd2, 5'd4));
    drive(0, 0, i_nop());
    drive(0, 0, i_nop());

    // saturate the counter, then reset in the middle of a stall
    drive(1, 0, i_nop());
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, i_mult(5'd1, 5'd2));
      repeat (5) drive(0, 0, i_mflo(5'd3));
    end
    expect_cnt(CNT_MAX);
    drive(0, 0, i_mult(5'd1, 5'd2));
    drive(0, 0, i_mflo(5'd3));
    drive(0, 0, i_mflo(5'd3));
    drive(1, 0, i_mflo(5'd3));
    expect_cnt(0);
    drive(0, 0, i_mflo(5'd3));
    drive(0, 0, i_nop());

    // randomized traffic
    drive(1, 0, i_nop());
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, i_rand());
    end

    done = 1'b1;
  end

  // Backstop so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
